// File: rtl/systolic_pe_db.sv
// -----------------------------------------------------------------------------
// systolic_pe_db
//
// Weight-stationary systolic processing element with a double-buffered weight.
// A shadow weight register is loaded from the north neighbour while the
// active weight is used for computation. A swap command copies shadow into
// active. Activations and their valid bit flow west to east. Partial sums
// flow north to south. Weights shift one PE per cycle down the column.
//
// Every sample that is taken in produces
//   out_sum = in_sum + in_data * active_weight
// MUL_LATENCY enabled cycles later. out_data and valid_out are delayed by the
// same amount. The product is formed at 2*DATA_SIZE bits, sign- or zero-
// extended according to SIGNED, and then fitted to ACC_SIZE bits.
//
// Optional feature (macro SYSTOLIC_PE_SATURATE_EN):
//   When the macro is defined, the accumulate clamps to the representable
//   range instead of wrapping. The extra output sat_out flags clamped samples.
//   When the macro is undefined, the sum wraps mod 2^ACC_SIZE and sat_out is
//   absent.
//
// Parameters:
//   DATA_SIZE   activation/weight width
//   ACC_SIZE    partial-sum width (>= DATA_SIZE)
//   MUL_LATENCY sample-to-result latency in enabled cycles (1..8)
//   SIGNED      1 = two's-complement arithmetic, 0 = unsigned
//
// Ports:
//   clk          clock
//   reset        synchronous active-high reset, highest priority
//   enable_in    global advance; 0 freezes every register
//   valid_in     qualifies in_data/in_sum
//   in_data      activation from the west
//   in_sum       partial sum from the north
//   wt_in        weight from the north neighbour's wt_out
//   wt_ld_in     load wt_in into the shadow weight
//   wt_swap_in   copy shadow weight into active weight
//   enable_out   combinational copy of enable_in
//   valid_out    valid aligned with out_data/out_sum
//   sat_out      (saturating build only) clamp applied to this sample
//   out_data     activation to the east
//   out_sum      partial sum to the south
//   wt_out       shadow weight, to the south neighbour
//   wt_ld_out    wt_ld_in delayed one cycle
//   wt_swap_out  wt_swap_in delayed one cycle
// -----------------------------------------------------------------------------
module systolic_pe_db #(
  parameter int DATA_SIZE   = 16,
  parameter int ACC_SIZE    = 32,
  parameter int MUL_LATENCY = 3,
  parameter bit SIGNED      = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable_in,
  input  logic                 valid_in,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic [ACC_SIZE-1:0]  in_sum,
  input  logic [DATA_SIZE-1:0] wt_in,
  input  logic                 wt_ld_in,
  input  logic                 wt_swap_in,
  output logic                 enable_out,
  output logic                 valid_out,
`ifdef SYSTOLIC_PE_SATURATE_EN
  output logic                 sat_out,
`endif
  output logic [DATA_SIZE-1:0] out_data,
  output logic [ACC_SIZE-1:0]  out_sum,
  output logic [DATA_SIZE-1:0] wt_out,
  output logic                 wt_ld_out,
  output logic                 wt_swap_out
);

  // Full-precision product width, and the width needed to extend it to the
  // accumulator when the accumulator is the wider of the two.
  localparam int PROD_W = 2 * DATA_SIZE;
  localparam int EXT_W  = (PROD_W > ACC_SIZE) ? PROD_W : ACC_SIZE;

  // The result word carries the sum and, in the saturating build, the clamp
  // flag as its MSB so both travel down the pipeline together.
`ifdef SYSTOLIC_PE_SATURATE_EN
  localparam int RES_W = ACC_SIZE + 1;
`else
  localparam int RES_W = ACC_SIZE;
`endif

  // Pipeline payload: {valid, data, result}.
  localparam int PAY_W = 1 + DATA_SIZE + RES_W;

  // With latency 1 the MAC sits in front of the single result register.
  // With longer latency the operands are registered first (stage 0), the MAC
  // follows, and MUL_LATENCY-1 result registers complete the delay.
  localparam int NSTAGE = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------

  // Product of two DATA_SIZE operands, extended per SIGNED to 2*DATA_SIZE,
  // then sign/zero extended or truncated to the accumulator width.
  function automatic logic [ACC_SIZE-1:0] acc_product(
    input logic [DATA_SIZE-1:0] a,
    input logic [DATA_SIZE-1:0] b
  );
    logic [PROD_W-1:0] xa;
    logic [PROD_W-1:0] xb;
    logic [PROD_W-1:0] p;
    logic [EXT_W-1:0]  ext;
    // Extending the operands to the product width first makes the low
    // PROD_W bits of an ordinary multiply equal to the signed product.
    xa = {PROD_W{SIGNED & a[DATA_SIZE-1]}};
    xa[DATA_SIZE-1:0] = a;
    xb = {PROD_W{SIGNED & b[DATA_SIZE-1]}};
    xb[DATA_SIZE-1:0] = b;
    p = xa * xb;
    ext = {EXT_W{SIGNED & p[PROD_W-1]}};
    ext[PROD_W-1:0] = p;
    return ext[ACC_SIZE-1:0];
  endfunction

  // Accumulate partial sum and product; clamps in the saturating build.
  function automatic logic [RES_W-1:0] accumulate(
    input logic [ACC_SIZE-1:0] s,
    input logic [ACC_SIZE-1:0] p
  );
`ifdef SYSTOLIC_PE_SATURATE_EN
    logic [ACC_SIZE:0]   raw;
    logic                ovf;
    logic [ACC_SIZE-1:0] clamp;
    raw = {1'b0, s} + {1'b0, p};
    if (SIGNED) begin
      // Signed overflow: operands share a sign that the result does not.
      ovf = (s[ACC_SIZE-1] == p[ACC_SIZE-1]) &&
            (raw[ACC_SIZE-1] != s[ACC_SIZE-1]);
      // Overflow direction follows the common operand sign.
      clamp = {ACC_SIZE{~s[ACC_SIZE-1]}};
      clamp[ACC_SIZE-1] = s[ACC_SIZE-1];
    end else begin
      // Unsigned overflow is the carry out of the adder.
      ovf = raw[ACC_SIZE];
      clamp = {ACC_SIZE{1'b1}};
    end
    if (ovf) begin
      return {1'b1, clamp};
    end else begin
      return {1'b0, raw[ACC_SIZE-1:0]};
    end
`else
    return s + p;
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Weight chain: shadow/active double buffer plus control forwarding
  // ---------------------------------------------------------------------------
  logic [DATA_SIZE-1:0] shadow_wt;
  logic [DATA_SIZE-1:0] active_wt;

  // Shadow/active weights and delayed load/swap strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_wt   <= {DATA_SIZE{1'b0}};
      active_wt   <= {DATA_SIZE{1'b0}};
      wt_ld_out   <= 1'b0;
      wt_swap_out <= 1'b0;
    end else if (enable_in) begin
      // Swap reads the pre-edge shadow, so a simultaneous load and swap
      // moves the old shadow into active and the new weight into shadow.
      if (wt_swap_in) begin
        active_wt <= shadow_wt;
      end
      if (wt_ld_in) begin
        shadow_wt <= wt_in;
      end
      wt_ld_out   <= wt_ld_in;
      wt_swap_out <= wt_swap_in;
    end
  end

  assign wt_out     = shadow_wt;
  assign enable_out = enable_in;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // MAC operand sources: either the raw inputs or the stage-0 registers.
  logic                 src_valid;
  logic [DATA_SIZE-1:0] src_data;
  logic [ACC_SIZE-1:0]  src_sum;
  logic [DATA_SIZE-1:0] src_wt;
  logic [RES_W-1:0]     mac_res;

  if (MUL_LATENCY == 1) begin : g_direct
    // The active weight is read before the edge, so a swap on this same
    // edge still leaves this sample with the old weight.
    assign src_valid = valid_in;
    assign src_data  = in_data;
    assign src_sum   = in_sum;
    assign src_wt    = active_wt;
  end else begin : g_opreg
    logic                 op_valid;
    logic [DATA_SIZE-1:0] op_data;
    logic [ACC_SIZE-1:0]  op_sum;
    logic [DATA_SIZE-1:0] op_wt;

    // Stage 0: capture the sample together with the weight it must use,
    // so later weight changes cannot affect it.
    always_ff @(posedge clk) begin
      if (reset) begin
        op_valid <= 1'b0;
        op_data  <= {DATA_SIZE{1'b0}};
        op_sum   <= {ACC_SIZE{1'b0}};
        op_wt    <= {DATA_SIZE{1'b0}};
      end else if (enable_in) begin
        op_valid <= valid_in;
        op_data  <= in_data;
        op_sum   <= in_sum;
        op_wt    <= active_wt;
      end
    end

    assign src_valid = op_valid;
    assign src_data  = op_data;
    assign src_sum   = op_sum;
    assign src_wt    = op_wt;
  end

  // Multiply-accumulate on the selected operands.
  always_comb begin
    mac_res = accumulate(src_sum, acc_product(src_data, src_wt));
  end

  logic [PAY_W-1:0] stage [NSTAGE];

  // Result delay line; invalid samples travel too so the output is always
  // a deterministic function of the inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSTAGE; i++) begin
        stage[i] <= {PAY_W{1'b0}};
      end
    end else if (enable_in) begin
      stage[0] <= {src_valid, src_data, mac_res};
      for (int i = 1; i < NSTAGE; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // Outputs come straight from the last pipeline register.
  logic [PAY_W-1:0] tail;
  assign tail      = stage[NSTAGE-1];
  assign valid_out = tail[PAY_W-1];
  assign out_data  = tail[PAY_W-2 -: DATA_SIZE];
  assign out_sum   = tail[ACC_SIZE-1:0];
`ifdef SYSTOLIC_PE_SATURATE_EN
  assign sat_out   = tail[ACC_SIZE];
`endif

endmodule

// File: doc/systolic_pe_db.md
Name: systolic_pe_db

Overview:
Weight-stationary systolic processing element, successor to the single-weight PE.
- Double-buffered (shadow/active) weight, so the next tile's weights stream in while the current tile computes.
- Parametrised multiply latency, separate accumulator width, signed/unsigned mode, and a valid bit that travels with the data.
- Tiles in a 2-D array: data and valid flow row-wise, partial sums flow column-wise, weights shift down the column.

Parameters:
- DATA_SIZE, 16: width of activations and weights.
- ACC_SIZE, 32: width of partial sums; must be >= DATA_SIZE.
- MUL_LATENCY, 3: cycles from in_data/in_sum sampled to out_sum/out_data valid; range 1..8.
- SIGNED, 1: 1 = two's-complement multiply; 0 = unsigned.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- enable_in  in  1  global advance; 0 freezes all state
- valid_in  in  1  in_data/in_sum qualify a sample
- in_data  in  DATA_SIZE  activation from the west
- in_sum  in  ACC_SIZE  partial sum from the north
- wt_in  in  DATA_SIZE  weight from the north neighbour's wt_out
- wt_ld_in  in  1  shift wt_in into the shadow register
- wt_swap_in  in  1  copy shadow into active
- enable_out  out  1  combinational copy of enable_in
- valid_out  out  1  valid aligned with out_data/out_sum
- out_data  out  DATA_SIZE  activation to the east
- out_sum  out  ACC_SIZE  partial sum to the south
- wt_out  out  DATA_SIZE  registered shadow weight, to the south neighbour
- wt_ld_out  out  1  wt_ld_in registered 1 cycle
- wt_swap_out  out  1  wt_swap_in registered 1 cycle

Behaviour:
- Reset (synchronous, priority over everything):
  - shadow, active, all pipeline stages, valid_out, out_data, out_sum, wt_out, wt_ld_out and wt_swap_out clear to 0 on the next edge.
  - Reset mid-operation discards in-flight samples; no valid_out pulse follows reset.
- Stall: enable_in=0 holds every register, including the weight chain. Outputs stay constant. A sample in flight resumes unchanged when enable_in returns to 1.
- Datapath, when enable_in=1:
  - Stage 0 samples in_data, in_sum, valid_in and the current active weight.
  - Product is 2*DATA_SIZE bits, sign- or zero-extended per SIGNED, then truncated/extended to ACC_SIZE.
  - out_sum = in_sum + product, wrapping mod 2^ACC_SIZE.
  - The result appears exactly MUL_LATENCY enabled cycles later. out_data and valid_out use the same delay.
- Invalid samples still propagate through the pipeline; valid_out=0 for them. out_sum/out_data are don't-care when valid_out=0, but must be deterministic.
- Weight load: wt_ld_in=1 → shadow <= wt_in. wt_out always equals shadow, giving a 1-cycle-per-PE shift down the column. wt_ld_out = wt_ld_in delayed one cycle.
- Weight swap: wt_swap_in=1 → active <= shadow at that edge.
  - Samples sampled on the same edge still use the old active weight.
  - Samples sampled from the next edge onward use the new weight.
  - wt_swap_out = wt_swap_in delayed one cycle, giving diagonal swap propagation.
- Simultaneous wt_ld_in and wt_swap_in: active takes the old shadow; shadow takes wt_in.
- Weight registers never alter samples already in the pipeline.
- Back-to-back valid samples are accepted every enabled cycle; throughput is 1 sample/cycle.

Optional Feature:
Macro SYSTOLIC_PE_SATURATE_EN.
- Defined: the accumulate saturates instead of wrapping.
  - SIGNED=1: clamps to [-2^(ACC_SIZE-1), 2^(ACC_SIZE-1)-1].
  - SIGNED=0: clamps to 2^ACC_SIZE-1.
  - Adds output sat_out (1 bit), aligned with valid_out; it is 1 when the clamp was applied to that sample.
- Undefined: wraps mod 2^ACC_SIZE; sat_out port is absent.

Test Plan:
- Basic MAC. Defaults; load weight 3 with ld, then swap; send in_data=5, in_sum=10, valid_in=1. → Exactly 3 cycles later: out_sum=25, out_data=5, valid_out=1. Valid stays 0 on all other cycles.
- Double buffer. Active=2; stream data 1,1,1,1. Load shadow=7 on cycle 1 and assert swap on cycle 2. → Samples 0..2 use weight 2; sample 3 uses 7. The simultaneous ld(9)+swap case gives active=7, shadow=9.
- Signed and width. SIGNED=1, DATA_SIZE=8, ACC_SIZE=16: weight=-128, data=-128, in_sum=0 → out_sum=16384. With SIGNED=0, data=0xFF, weight=0xFF → 65025.
- Stall. Insert 2 cycles of enable_in=0 mid-flight. → The result appears after 3 enabled cycles (5 clocks) with the correct value. Outputs are held during the stall.
- Reset mid-operation. Assert reset with 3 valid samples in flight. → The next cycle has all outputs 0. No valid_out until new input arrives. Weights read back as 0 via wt_out.
- Wrap/saturate. ACC_SIZE=16, in_sum=32767, product=1. → Without macro: out_sum=-32768. With SYSTOLIC_PE_SATURATE_EN: out_sum=32767, sat_out=1.
